// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// WIDTH bits are split into STAGES registered slices. Each slice is built from
// GROUP-bit CLA cells plus one group-lookahead level.
// Optional macro CLA_ADDSUB_SAT_EN adds a 'sat' input. With sat=1, an
// overflowing result clamps to signed max or signed min.

module cla_cell #(
  parameter int GROUP = 4
)(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             g,
  output logic             p
);
  logic [GROUP-1:0] gb, pb, c;
  logic             gacc;

  assign gb = a & b;
  assign pb = a ^ b;

  // in-cell carries, bit by bit from the cell carry-in
  always_comb begin
    c[0] = ci;
    for (int i = 1; i < GROUP; i++) c[i] = gb[i-1] | (pb[i-1] & c[i-1]);
  end

  // group generate is independent of ci so the lookahead level has no loop
  always_comb begin
    gacc = 1'b0;
    for (int i = 0; i < GROUP; i++) gacc = gb[i] | (pb[i] & gacc);
  end

  assign s = pb ^ c;
  assign g = gacc;
  assign p = &pb;
endmodule

module cla_slice #(
  parameter int SW    = 16,
  parameter int GROUP = 4
)(
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);
  localparam int NG = SW / GROUP;

  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;
  logic          t;

  cla_cell #(.GROUP(GROUP)) u_cell [NG-1:0] (
    .a(a), .b(b), .ci(gc[NG-1:0]), .s(s), .g(gg), .p(gp)
  );

  // group lookahead: carry into cell j as a flat sum of products of G/P
  always_comb begin
    gc = '0;
    t  = 1'b0;
    for (int j = 0; j <= NG; j++) begin
      t = ci;
      for (int i = 0; i < j; i++) t = t & gp[i];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end
  end

  assign co = gc[NG];
endmodule

module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
)(
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef CLA_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;

  // A beat carries the full operands so that their high bits skew along the
  // pipe. It also carries the partial sum, the inter-slice carry and sat.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             sat;
  } beat_t;

  beat_t             in_b;
  beat_t             src [STAGES];
  beat_t             pq  [STAGES];
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES-1:0] en;
  logic              sat_in;
  logic              unused_tail;

`ifdef CLA_ADDSUB_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  // subtract as A + ~B + 1, and borrow-in folds into the inverted carry
  assign in_b     = {a, (sub ? ~b : b), {WIDTH{1'b0}}, (cin ^ sub), sat_in};
  assign vld_pipe = {vld_q, in_valid};
  assign in_ready = en[0];
  assign out_valid = vld_q[STAGES];
  assign sum      = pq[STAGES-1].s;

  // slot k loads when it is empty or its current beat moves on
  always_comb begin
    en = '0;
    en[STAGES-1] = !vld_q[STAGES] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) en[k] = !vld_q[k+1] | en[k+1];
  end

  // valid bits shift with their beats; a clear discards everything in flight
  always_ff @(posedge clk or posedge clr) begin
    if (clr) vld_q <= '0;
    else
      for (int k = 0; k < STAGES; k++)
        if (en[k]) vld_q[k+1] <= vld_pipe[k];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [SW-1:0] s_sl;
    logic          co_sl;
    beat_t         nb;

    if (k == 0) begin : g_src_in
      assign src[k] = in_b;
    end else begin : g_src_reg
      assign src[k] = pq[k-1];
    end

    cla_slice #(.SW(SW), .GROUP(GROUP)) u_slice (
      .a (src[k].a[k*SW +: SW]),
      .b (src[k].b[k*SW +: SW]),
      .ci(src[k].c),
      .s (s_sl),
      .co(co_sl)
    );

    // merge this slice's bits into the beat and pass its carry on
    always_comb begin
      nb = src[k];
      nb.s[k*SW +: SW] = s_sl;
      nb.c = co_sl;
    end

    if (k < STAGES - 1) begin : g_mid
      // intermediate slice register
      always_ff @(posedge clk or posedge clr) begin
        if (clr)        pq[k] <= '0;
        else if (en[k]) pq[k] <= nb;
      end
    end else begin : g_last
      logic             c_msb, ovf_n;
      logic [WIDTH-1:0] s_fin;
      beat_t            nl;

      // flags come from the final carries; the MSB carry-in is recovered
      // from the MSB sum bit, and saturation picks the clamp from the
      // wrapped sign
      always_comb begin
        c_msb = src[k].a[WIDTH-1] ^ src[k].b[WIDTH-1] ^ nb.s[WIDTH-1];
        ovf_n = c_msb ^ co_sl;
        s_fin = nb.s;
        if (src[k].sat && ovf_n)
          s_fin = nb.s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        nl   = nb;
        nl.s = s_fin;
      end

      // output register, which holds its value while the output is stalled
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          pq[k] <= '0;
          cout  <= 1'b0;
          ovf   <= 1'b0;
          zero  <= 1'b0;
        end else if (en[k]) begin
          pq[k] <= nl;
          cout  <= co_sl;
          ovf   <= ovf_n;
          zero  <= ~|s_fin;
        end
      end
    end
  end

  // operand copies and carry in the output slot have no further consumer
  assign unused_tail = ^{pq[STAGES-1].a, pq[STAGES-1].b, pq[STAGES-1].c, pq[STAGES-1].sat};
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe (WIDTH=32, STAGES=2).
// The driver pushes the expected results, and the monitor pops and compares them.
module tb_cla_addsub_pipe;
  localparam int W  = 32;
  localparam int ST = 2;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
    int           cyc;
    bit           lat;
  } exp_t;

  logic         clk = 0, clr = 1, in_valid = 0, sub = 0, cin = 0, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] sum;
`ifdef CLA_ADDSUB_SAT_EN
  logic         sat = 0;
`endif

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(ST)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
`ifdef CLA_ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t         sbq[$];
  int           pass_cnt = 0, tot_cnt = 0, res_idx = 0;
  bit           mon_en = 0, lat_chk = 0, held = 0, saw_full = 0;
  logic [W+2:0] held_v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, ov, z);
    exp_t e;
    e.s = s; e.co = co; e.ov = ov; e.z = z; e.cyc = 0; e.lat = 0;
    return e;
  endfunction

  // reference: plain wide add of the two's complement operands
  function automatic exp_t model(input logic [W-1:0] x, y, input logic s_, c_);
    logic [W-1:0] be;
    logic [W:0]   r;
    be = s_ ? ~y : y;
    r  = {1'b0, x} + {1'b0, be} + (W+1)'(c_ ^ s_);
    return mk(r[W-1:0], r[W], (x[W-1] ^ be[W-1] ^ r[W-1]) ^ r[W], r[W-1:0] == '0);
  endfunction

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                      input logic ts, input logic tc, input exp_t e);
    int n;
    @(negedge clk);
    a = ta; b = tb2; sub = ts; cin = tc; in_valid = 1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      saw_full = 1;
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 1, 0);
      in_valid = 0;
    end else begin
      e.cyc = cyc; e.lat = lat_chk;
      sbq.push_back(e);
      @(posedge clk); #1;
      in_valid = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk); #3;
    chk("drain_left", sbq.size(), 0);
  endtask

  // monitor: pop on each handshake and check that a stalled result holds
  always @(negedge clk) begin
    #2;
    if (!mon_en) held = 0;
    else begin
      if (held) chk("stall_hold", {out_valid, sum, cout, ovf, zero}, {1'b1, held_v});
      held = 0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("res%0d", res_idx), {sum, cout, ovf, zero}, {e.s, e.co, e.ov, e.z});
          if (e.lat) chk($sformatf("lat%0d", res_idx), cyc - e.cyc, ST);
          res_idx++;
        end
      end else if (out_valid) begin
        held   = 1;
        held_v = {sum, cout, ovf, zero};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e3;
    repeat (2) @(negedge clk);
    #1 chk("rst_outputs", {out_valid, sum, cout, ovf, zero}, 0);
    clr = 0;
    #1 chk("rst_in_ready", in_ready, 1);
    mon_en = 1; lat_chk = 1;

    // directed vectors, back to back and unstalled
    send(32'h0000_0005, 32'h0000_0003, 0, 0, mk(32'h0000_0008, 0, 0, 0));
    send(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, mk(32'h0000_0000, 1, 0, 1));
`ifdef CLA_ADDSUB_SAT_EN
    sat = 1;
    e3 = mk(32'h7FFF_FFFF, 0, 1, 0);
`else
    e3 = mk(32'h8000_0000, 0, 1, 0);
`endif
    send(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, e3);
`ifdef CLA_ADDSUB_SAT_EN
    sat = 0;
`endif
    send(32'h0000_0005, 32'h0000_0007, 1, 0, mk(32'hFFFF_FFFE, 0, 0, 0));
    send(32'h0000_0007, 32'h0000_0005, 1, 1, mk(32'h0000_0001, 1, 0, 0));
    send(32'h8000_0000, 32'h0000_0001, 1, 0, mk(32'h7FFF_FFFF, 1, 1, 0));
    send(32'h0000_FFFF, 32'h0000_0001, 0, 0, mk(32'h0001_0000, 0, 0, 0));
    send(32'hFFFF_FFFF, 32'h0000_0000, 0, 1, mk(32'h0000_0000, 1, 0, 1));
    send(32'h0000_0005, 32'h0000_0005, 1, 0, mk(32'h0000_0000, 1, 0, 1));
    send(32'h8000_0000, 32'h8000_0000, 0, 0, mk(32'h0000_0000, 1, 1, 1));
    drain();
    lat_chk = 0;

    // 16 back-to-back beats with a 3-cycle output stall mid-stream
    fork
      for (int i = 0; i < 16; i++) begin
        logic [W-1:0] x, y;
        x = 32'h1357_9BDF * (i + 1);
        y = 32'h0F0F_F0F0 ^ (i << 11);
        send(x, y, i[0], i[1], model(x, y, i[0], i[1]));
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 0;
        repeat (3) @(negedge clk);
        out_ready = 1;
      end
    join
    drain();
    chk("in_ready_dropped_when_full", saw_full, 1);

    // clear with two beats in flight: both must vanish
    mon_en = 0; out_ready = 0;
    @(negedge clk);
    a = 32'h1; b = 32'h1; sub = 0; cin = 0; in_valid = 1;
    @(negedge clk);
    a = 32'h2;
    @(negedge clk);
    in_valid = 0;
    #1 chk("inflight_valid", out_valid, 1);
    clr = 1;
    #1 chk("clr_outputs", {out_valid, sum, cout, ovf, zero}, 0);
    @(negedge clk);
    clr = 0; out_ready = 1;
    #1 chk("clr_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk($sformatf("no_stale%0d", i), out_valid, 0);
    end
    mon_en = 1;
    send(32'h0000_0005, 32'h0000_0003, 0, 0, mk(32'h0000_0008, 0, 0, 0));
    drain();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
